// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master) and imem (slave).
interface instr_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem fetch, 2-entry {instr, pc} queue toward decode.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirects set sticky misalign_err and halt fetching.
module instr_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_unit_if.master imem,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [31:0]        instr,
   output logic [XLEN-1:0]    instr_pc,
   output logic [6:0]         opcode,
   output logic               misalign_err
);

   // state  | meaning
   // S_IDLE | nothing outstanding
   // S_WAIT | one response owed, it will be kept
   // S_DROP | one response owed, it will be discarded
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [XLEN-1:0]         pc_q, pc_d;
   logic [XLEN-1:0]         req_pc_q, req_pc_d;
   logic [1:0][31:0]        fifo_instr_q, fifo_instr_d;
   logic [1:0][XLEN-1:0]    fifo_pc_q, fifo_pc_d;
   logic [1:0]              count_q, count_d;

   logic                    req_fire;
   logic                    push;
   logic                    pop;
   logic                    fetch_halt;
   logic [XLEN-1:0]         redir_target;

`ifdef FETCH_ALIGN_CHK_EN
   logic                    halted_q, halted_d;
   logic                    redir_bad;

   assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redir_target = redirect_pc;
   assign fetch_halt   = halted_q;
   assign misalign_err = halted_q;

   always_comb begin
      halted_d = halted_q | redir_bad;
   end

   always_ff @(posedge clk) begin
      if (rst) halted_q <= 1'b0;
      else     halted_q <= halted_d;
   end
`else
   logic                    unused_redir_lsb;

   assign unused_redir_lsb = ^redirect_pc[1:0];
   assign redir_target     = {redirect_pc[XLEN-1:2], 2'b00};
   assign fetch_halt       = 1'b0;
   assign misalign_err     = 1'b0;
`endif

   assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
   assign push     = imem.imem_rsp_valid && (state_q == S_WAIT) && !redirect_valid;
   assign pop      = instr_valid && instr_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // A response coinciding with a redirect is always discarded, so the FSM lands in IDLE.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         if (imem.imem_rsp_valid)     state_d = S_IDLE;
         else if (state_q == S_WAIT)  state_d = S_DROP;
      end else begin
         case (state_q)
            S_IDLE:         if (req_fire)            state_d = S_WAIT;
            S_WAIT, S_DROP: if (imem.imem_rsp_valid) state_d = S_IDLE;
            default:                                 state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      imem.imem_req_valid = (state_q == S_IDLE) && (count_q != 2'd2) &&
                            !redirect_valid && !rst && !fetch_halt;
      imem.imem_addr      = pc_q;
   end

   // Vacated queue slots are zeroed so the head reads 0 whenever the queue is empty.
   always_comb begin
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;
      count_d      = count_q;
      if (redirect_valid) begin
         pc_d         = redir_target;
         fifo_instr_d = '0;
         fifo_pc_d    = '0;
         count_d      = 2'd0;
      end else begin
         if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
         end
         if (pop) begin
            fifo_instr_d[0] = fifo_instr_q[1];
            fifo_pc_d[0]    = fifo_pc_q[1];
            fifo_instr_d[1] = '0;
            fifo_pc_d[1]    = '0;
            count_d         = count_q - 2'd1;
         end
         if (push) begin
            if (count_d == 2'd0) begin
               fifo_instr_d[0] = imem.imem_rdata;
               fifo_pc_d[0]    = req_pc_q;
            end else begin
               fifo_instr_d[1] = imem.imem_rdata;
               fifo_pc_d[1]    = req_pc_q;
            end
            count_d = count_d + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         req_pc_q     <= '0;
         fifo_instr_q <= '0;
         fifo_pc_q    <= '0;
         count_q      <= 2'd0;
      end else begin
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         fifo_instr_q <= fifo_instr_d;
         fifo_pc_q    <= fifo_pc_d;
         count_q      <= count_d;
      end
   end

   assign instr_valid = (count_q != 2'd0);
   assign instr       = fifo_instr_q[0];
   assign instr_pc    = fifo_pc_q[0];
   assign opcode      = fifo_instr_q[0][6:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model with random latency feeds kept responses
// into an expected queue; a separate monitor compares the decode-side head against it.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  opcode;
   logic        misalign_err;

   instr_fetch_unit_if #(.XLEN(32)) imem_if ();

   instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem_if),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .opcode         (opcode),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] instr; logic [31:0] pc; } item_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit keep; bit live; } pend_t;

   item_t       exp_q[$];
   pend_t       pend[$];
   logic [31:0] force_data[$];
   logic [31:0] dlv_pc[$];
   logic [31:0] dlv_instr[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          sz_s = 0;
   logic [31:0] m_pc = RESET_PC;
   bit          m_halt = 0;
   bit          exp_mis = 0;

   int          lat_min = 1, lat_max = 1;
   bit          ctl_rand = 0, ctl_ready = 1, ctl_iready = 1, ctl_rst = 0, hold_drain = 0;
   int          redir_mode = 0;
   logic [31:0] redir_tgt = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %08h required %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: decode-side head must equal the oldest kept response not yet consumed.
   initial begin
      bit rst_prev;
      rst_prev = 1'b1;
      @(posedge clk);
      forever begin
         @(negedge clk);
         sz_s = exp_q.size();
         if (rst_prev) begin
            chk("rst_instr_valid", 32'(instr_valid), 32'h0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
            chk("rst_opcode", 32'(opcode), 32'h0);
            chk("rst_misalign", 32'(misalign_err), 32'h0);
         end
         chk("instr_valid", 32'(instr_valid), 32'(sz_s != 0));
         if (sz_s != 0) begin
            chk("instr", instr, exp_q[0].instr);
            chk("instr_pc", instr_pc, exp_q[0].pc);
            chk("opcode", 32'(opcode), 32'(exp_q[0].instr[6:0]));
         end else begin
            chk("instr_empty", instr, 32'h0);
            chk("opcode_empty", 32'(opcode), 32'h0);
         end
         chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
         if (instr_valid && instr_ready && !redirect_valid && !rst && sz_s != 0) begin
            dlv_pc.push_back(instr_pc);
            dlv_instr.push_back(instr);
            void'(exp_q.pop_front());
         end
         rst_prev = rst;
      end
   end

   // One clock of stimulus plus the memory/fetch model update for the coming edge.
   task automatic cycle();
      bit    rsp_now, head_live, owed, fire, exp_rv;
      pend_t e;
      item_t it;
      @(posedge clk); #1;
      cyc++;
      rst     = ctl_rst;
      ctl_rst = 1'b0;
      rsp_now   = (pend.size() > 0) && (pend[0].due <= cyc);
      head_live = rsp_now && pend[0].live;
      imem_if.imem_rsp_valid = rsp_now;
      imem_if.imem_rdata     = rsp_now ? pend[0].data : $urandom();
      owed = 1'b0;
      foreach (pend[i]) if (pend[i].live) owed = 1'b1;
      case (redir_mode)
         1:       fire = 1'b1;
         2:       fire = owed && !rsp_now;
         3:       fire = head_live;
         default: fire = 1'b0;
      endcase
      redirect_valid = fire;
      redirect_pc    = fire ? redir_tgt : $urandom();
      if (fire) redir_mode = 0;
      if (hold_drain && pend.size() == 0) hold_drain = 1'b0;
      if (ctl_rand) begin
         imem_if.imem_req_ready = ($urandom_range(0, 99) < 70);
         instr_ready            = ($urandom_range(0, 99) < 65);
      end else begin
         imem_if.imem_req_ready = ctl_ready;
         instr_ready            = ctl_iready;
      end
      if (hold_drain) imem_if.imem_req_ready = 1'b0;

      @(negedge clk); #1;
      exp_rv = !rst && !redirect_valid && !owed && !m_halt && (sz_s < 2);
      chk("imem_req_valid", 32'(imem_if.imem_req_valid), 32'(exp_rv));
      if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
         chk("imem_addr", imem_if.imem_addr, m_pc);
         e.addr = m_pc;
         e.data = (force_data.size() > 0) ? force_data.pop_front() : $urandom();
         e.due  = cyc + $urandom_range(lat_min, lat_max);
         e.keep = 1'b1;
         e.live = 1'b1;
         pend.push_back(e);
         m_pc = m_pc + 32'd4;
      end
      if (rsp_now) begin
         e = pend.pop_front();
         if (e.live && e.keep && !redirect_valid && !rst) begin
            it.instr = e.data;
            it.pc    = e.addr;
            exp_q.push_back(it);
         end
      end
      if (redirect_valid) begin
         exp_q.delete();
         foreach (pend[i]) pend[i].keep = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
         if (redirect_pc[1:0] != 2'b00) begin
            m_halt  = 1'b1;
            exp_mis = 1'b1;
         end
         m_pc = redirect_pc;
`else
         m_pc = redirect_pc & ~32'h3;
`endif
      end
      if (rst) begin
         exp_q.delete();
         foreach (pend[i]) pend[i].live = 1'b0;
         m_pc    = RESET_PC;
         m_halt  = 1'b0;
         exp_mis = 1'b0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_until_dlv(input int target, input int bound, input string name);
      for (int i = 0; i < bound && dlv_pc.size() < target; i++) cycle();
      if (dlv_pc.size() < target) chk(name, 32'(dlv_pc.size()), 32'(target));
   endtask

   task automatic do_reset();
      ctl_ready  = 1'b0;
      ctl_rst    = 1'b1;
      hold_drain = 1'b1;
      cycle();
      run(5);
   endtask

   task automatic drain();
      ctl_ready  = 1'b0;
      ctl_iready = 1'b1;
      run(6);
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      imem_if.imem_req_ready = 1'b0;
      imem_if.imem_rsp_valid = 1'b0;
      imem_if.imem_rdata = 32'h0;
      repeat (2) begin ctl_rst = 1'b1; cycle(); end

      // sequential fetch, 1-cycle memory, decode always ready
      ctl_ready = 1'b1; ctl_iready = 1'b1;
      run_until_dlv(3, 40, "seq_timeout");
      chk("seq_pc0", dlv_pc[0], 32'h0);
      chk("seq_pc1", dlv_pc[1], 32'h4);
      chk("seq_pc2", dlv_pc[2], 32'h8);

      // decode stall fills both slots, then drains in order
      do_reset();
      ctl_iready = 1'b0;
      force_data.push_back(32'h0050_0093);
      force_data.push_back(32'h00A0_0113);
      ctl_ready = 1'b1;
      run(12);
      chk("stall_instr_valid", 32'(instr_valid), 32'h1);
      n0 = dlv_pc.size();
      ctl_iready = 1'b1;
      run_until_dlv(n0 + 3, 20, "stall_timeout");
      chk("stall_instr0", dlv_instr[n0], 32'h0050_0093);
      chk("stall_instr1", dlv_instr[n0 + 1], 32'h00A0_0113);
      chk("stall_pc2", dlv_pc[n0 + 2], 32'h8);

      // redirect while a slow response is owed; the late word must vanish
      drain();
      force_data.push_back(32'hDEAD_BEEF);
      lat_min = 3; lat_max = 3;
      redir_tgt = 32'h100; redir_mode = 2;
      n0 = dlv_pc.size();
      ctl_ready = 1'b1;
      run_until_dlv(n0 + 1, 30, "drop_timeout");
      chk("drop_next_pc", dlv_pc[n0], 32'h100);

      // redirect coinciding with the response
      lat_min = 1; lat_max = 1;
      drain();
      redir_tgt = 32'h200; redir_mode = 3;
      n0 = dlv_pc.size();
      ctl_ready = 1'b1;
      run_until_dlv(n0 + 1, 30, "same_cycle_timeout");
      chk("same_cycle_pc", dlv_pc[n0], 32'h200);

      // reset with one queued entry and one request outstanding
      drain();
      ctl_iready = 1'b0;
      lat_min = 3; lat_max = 3;
      ctl_ready = 1'b1;
      for (int i = 0; i < 20 && !(exp_q.size() == 1 && pend.size() == 1); i++) cycle();
      chk("rst_setup_queued", 32'(instr_valid), 32'h1);
      do_reset();
      lat_min = 1; lat_max = 1;
      ctl_iready = 1'b1;
      n0 = dlv_pc.size();
      ctl_ready = 1'b1;
      run_until_dlv(n0 + 1, 20, "post_rst_timeout");
      chk("post_rst_pc", dlv_pc[n0], RESET_PC);

      // misaligned redirect
      drain();
      redir_tgt = 32'h102; redir_mode = 1;
      n0 = dlv_pc.size();
      ctl_ready = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
      run(10);
      chk("misalign_set", 32'(misalign_err), 32'h1);
      chk("misalign_halt", 32'(imem_if.imem_req_valid), 32'h0);
      do_reset();
      chk("misalign_cleared", 32'(misalign_err), 32'h0);
`else
      run_until_dlv(n0 + 1, 20, "misalign_timeout");
      chk("misalign_pc", dlv_pc[n0], 32'h100);
      chk("misalign_flag", 32'(misalign_err), 32'h0);
`endif

      // randomized traffic
      ctl_rand = 1'b1;
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            redir_mode = $urandom_range(1, 3);
            redir_tgt  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 4095))
                                                      : {$urandom_range(0, 1023), 2'b00};
         end
         if ($urandom_range(0, 199) == 0) begin
            ctl_rst    = 1'b1;
            hold_drain = 1'b1;
         end
         cycle();
      end
      ctl_rand = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the RISC-V core: holds the program counter, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions in a 2-entry queue. The queue head goes to decode over a valid/ready handshake. `opcode` feeds the main decoder directly. Branch/jump redirects from execute flush the queue and discard any in-flight response.

## Interface
- `XLEN`, 32, data/address width.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  XLEN  fetch address; equals `pc`.
- `imem_rsp_valid`  in  1  read data valid; no backpressure.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle redirect pulse.
- `redirect_pc`  in  XLEN  redirect target.
- `instr_valid`  out  1  queue non-empty.
- `instr_ready`  in  1  decode accepts the head.
- `instr`  out  32  head instruction; 0 when the queue is empty.
- `instr_pc`  out  XLEN  PC of the head.
- `opcode`  out  7  `instr[6:0]`.
- `misalign_err`  out  1  sticky misaligned-redirect flag.

## Operation
- **State:** `pc`, `req_pc`, 2-entry FIFO of {instr, pc}, `count` (0..2), and an FSM.
- **FSM states:**
  - IDLE: nothing outstanding.
  - WAIT: one response owed; it will be kept.
  - DROP: one response owed; it will be discarded.
- **Request issue:** `imem_req_valid` = state==IDLE && count<2 && !redirect_valid && !rst (plus !halted under the macro).
- **Request accept** (`imem_req_valid && imem_req_ready`): `req_pc<=pc`, `pc<=pc+4` (mod 2^XLEN, wraps silently), IDLE→WAIT.
- **Response in WAIT:** push {`imem_rdata`, `req_pc`}, WAIT→IDLE.
- **Response in DROP:** discard, DROP→IDLE.
- **Response in IDLE:** ignored.
- **Pop:** `instr_valid && instr_ready`; the head advances.
- **Push and pop in the same cycle:** `count` is unchanged and order is preserved.
- **Full:** count==2 blocks issue, so push into a full queue is impossible.
- **Redirect** (highest priority):
  - Queue flushed (`count<=0`) and `pc<=redirect_pc`.
  - Any pop in that cycle is ignored.
  - State WAIT→DROP; IDLE and DROP are unchanged.
  - A response arriving in the redirect cycle is discarded and the state goes to IDLE. This applies whether the state was WAIT or DROP.
- **Reset values** (at any time, including mid-request): `pc=RESET_PC`, count=0, state IDLE, `instr_valid=0`, `instr=0`, `instr_pc=0`, `opcode=0`, `imem_req_valid=0`, `misalign_err=0`. Responses owed at reset are ignored, since the state is IDLE.

## Timing
- `imem_req_valid` and `imem_addr` are combinational from registers and `redirect_valid`. All other outputs are registered.
- **Memory latency:** the response arrives no earlier than 1 cycle after acceptance.
  - Accept at edge N; response sampled at edge N+k (k≥1); `instr_valid` high after edge N+k.
  - Next request is issued in the cycle after the response, provided count<2.
- **Throughput:** 1 instruction per 2 cycles with k=1, while decode keeps up.
- **After redirect at edge R:**
  - If IDLE: first request to `redirect_pc` in cycle R+1.
  - If an owed response was discarded: request in the cycle after the discard.
- **Decode stalled** (`instr_ready=0`): at most 2 instructions are held and requests stop. Re-issue happens the cycle after the pop that frees a slot.

## Configuration
- **`FETCH_ALIGN_CHK_EN` defined:**
  - A redirect with `redirect_pc[1:0]!=2'b00` performs the normal flush/drop.
  - It also sets `misalign_err` (sticky until `rst`) and halts: no further requests.
  - `pc` takes `redirect_pc` unmodified.
- **Undefined:**
  - `pc<=redirect_pc & ~3` on every redirect.
  - `misalign_err` is tied to 0 and no halt exists.

## Test plan
- Reset, then `imem_req_ready=1` with 1-cycle response latency and `instr_ready=1` → addresses 0x0, 0x4, 0x8 in order. Each `instr_pc` matches its address, `opcode=imem_rdata[6:0]`.
- `instr_ready=0`, return 0x00500093 then 0x00A00113 → `instr_valid=1`, count 2, no third request. Raise `instr_ready` → both delivered in order, next request 0x8 issued the cycle after the first pop.
- Redirect to 0x100 while in WAIT; response 0xDEADBEEF arrives 3 cycles later → response discarded, queue empty. Next request is 0x100, issued the cycle after the discard.
- Redirect to 0x200 in the same cycle the WAIT response arrives → response discarded; request 0x200 issued the next cycle; `instr_valid` stays 0 until that response.
- Pulse `rst` with 1 queued and 1 outstanding → all outputs at reset values the next cycle. The late response is ignored. First request is `RESET_PC`.
- With `FETCH_ALIGN_CHK_EN`, redirect to 0x102 → `misalign_err=1`, no requests until reset. Without the macro → request to 0x100, `misalign_err=0`.
